// File: rtl/sd_block_arbiter_if.sv
// hps_io virtual-disk block channel: LBA, one-hot rd/wr strobes,
// ack and the buffer byte stream. master = arbiter, slave = hps_io.
interface sd_block_arbiter_if;
    logic [31:0] sd_lba;
    logic [3:0]  sd_rd;
    logic [3:0]  sd_wr;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_wr
    );
endinterface

// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing one hps_io block channel between
// FDD0, FDD1, SASI and SRAM (slots 0..3).
// Ports: clk_sys, reset (async, active high); req_rd/req_wr/req_lba/
//   req_buff_din per-slot requests; buff_wr/done/err per-slot returns;
//   busy, cur_slot status; sd (master modport) toward hps_io.
// Optional: SD_BLOCK_ARBITER_TIMEOUT_EN adds an ack watchdog that
//   aborts ISSUE after TIMEOUT_CYCLES and pulses err with done.
module sd_block_arbiter #(
    parameter int          NREQ           = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [32*NREQ-1:0]   req_lba,
    input  logic [8*NREQ-1:0]    req_buff_din,
    output logic [NREQ-1:0]      buff_wr,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic [1:0]           cur_slot,
    sd_block_arbiter_if.master   sd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic            dir_rd;
    logic [NREQ-1:0] pending;
    logic            found;
    logic [1:0]      g;
    logic [3:0]      oh_g;
    logic [3:0]      oh_cur;

    assign pending = req_rd | req_wr;
    assign oh_g    = 4'b0001 << g;
    assign oh_cur  = 4'b0001 << cur_slot;
    assign busy    = (state != IDLE);

    // First pending slot after the last grant, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        g     = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            if (!found && pending[rr_ptr + 2'(k)]) begin
                found = 1'b1;
                g     = rr_ptr + 2'(k);
            end
        end
    end

    // Ack may already be high when ISSUE is entered, so only XFER
    // forwards buffer strobes.
    assign buff_wr = (state == XFER && sd.sd_ack && sd.sd_buff_wr)
                   ? oh_cur : 4'b0000;

    assign sd.sd_buff_din = busy
                          ? req_buff_din[{cur_slot, 3'b000} +: 8]
                          : 8'd0;

`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
    logic [31:0] cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err = '0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 2'd3;
            dir_rd    <= 1'b0;
            cur_slot  <= 2'd0;
            sd.sd_lba <= 32'd0;
            sd.sd_rd  <= 4'b0000;
            sd.sd_wr  <= 4'b0000;
            done      <= '0;
`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
            err       <= '0;
            cnt       <= 32'd0;
`endif
        end else begin
            done <= '0;
`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
            err  <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (found) begin
                        cur_slot  <= g;
                        sd.sd_lba <= req_lba[{g, 5'b00000} +: 32];
                        dir_rd    <= req_rd[g];
                        rr_ptr    <= g;
                        state     <= ISSUE;
`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
                        cnt       <= 32'd0;
`endif
                    end
                end
                ISSUE: begin
                    if (sd.sd_ack) begin
                        sd.sd_rd <= 4'b0000;
                        sd.sd_wr <= 4'b0000;
                        state    <= XFER;
`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
                    end else if (cnt == TIMEOUT_CYCLES - 32'd1) begin
                        sd.sd_rd <= 4'b0000;
                        sd.sd_wr <= 4'b0000;
                        err      <= oh_cur;
                        done     <= oh_cur;
                        state    <= DONE;
`endif
                    end else begin
                        // Strobe rises one cycle after grant.
                        sd.sd_rd <= dir_rd ? oh_cur : 4'b0000;
                        sd.sd_wr <= dir_rd ? 4'b0000 : oh_cur;
`ifdef SD_BLOCK_ARBITER_TIMEOUT_EN
                        cnt      <= cnt + 32'd1;
`endif
                    end
                end
                XFER: begin
                    if (!sd.sd_ack) begin
                        done  <= oh_cur;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Holdoff lets the requester drop its level request.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Shares the single hps_io virtual-disk block channel between four requesters: FDD0, FDD1, SASI and SRAM (slots 0..3).
- The channel consists of sd_lba, sd_rd/sd_wr, sd_ack and the sd_buff_* byte stream.
- Grants one request at a time in round-robin order, latches the requester's LBA and direction, and drives the one-hot sd_rd/sd_wr toward hps_io.
- Routes buffer bytes to and from the granted slot and returns a one-cycle completion pulse.
- Sits in emu between hps_io and the X68000 top, which then uses per-drive handshakes only.

Parameters:
- NREQ, 4, number of requester slots; fixed at 4 to match the hps_io VDNUM=4 configuration.
- TIMEOUT_CYCLES, 32'd50_000_000, ack watchdog limit in clk_sys cycles; used only with the optional feature.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_rd  in  4  per-slot read request; level, held until done.
- req_wr  in  4  per-slot write request; level, held until done.
- req_lba  in  128  per-slot LBA; slot i occupies bits [32i+31:32i].
- req_buff_din  in  32  per-slot write byte; slot i occupies bits [8i+7:8i].
- buff_wr  out  4  per-slot copy of sd_buff_wr; only the granted bit can be high.
- done  out  4  one-cycle completion pulse for the granted slot.
- err  out  4  one-cycle timeout pulse; always 0 without the optional feature.
- busy  out  1  high in every state except IDLE.
- cur_slot  out  2  granted slot index; holds the last granted value while IDLE.
- sd_lba  out  32  LBA to hps_io.
- sd_rd  out  4  one-hot read strobe to hps_io.
- sd_wr  out  4  one-hot write strobe to hps_io.
- sd_ack  in  1  hps_io transfer acknowledge.
- sd_buff_wr  in  1  hps_io buffer write strobe.
- sd_buff_din  out  8  byte returned to hps_io from the granted slot.

Behaviour:
- Reset values (async assert, release on clk_sys edge):
  - state = IDLE, rr_ptr = 3 (slot 0 wins first).
  - sd_rd = sd_wr = 0, sd_lba = 0, sd_buff_din = 0.
  - buff_wr = done = err = 0, busy = 0, cur_slot = 0.
- IDLE:
  - A slot is pending when req_rd[i] | req_wr[i].
  - Search starts at rr_ptr+1 mod 4 and wraps; the first pending slot g is granted.
  - On grant, register: cur_slot = g; sd_lba = req_lba[g]; dir = read if req_rd[g], else write. If both rd and wr are set, read wins.
  - rr_ptr <= g. Next state is ISSUE.
  - No pending slot: remain in IDLE.
- ISSUE:
  - Drive sd_rd[g] = 1 (read) or sd_wr[g] = 1 (write); all other strobe bits stay 0. Latency from request to strobe is 2 cycles.
  - When sd_ack = 1 is sampled: clear the strobe on that edge and go to XFER.
  - sd_ack already high on entry counts as ack.
- XFER:
  - buff_wr[g] = sd_buff_wr, combinational, asserted only while busy & sd_ack.
  - sd_buff_din = req_buff_din[g] (combinational mux); 0 when not busy.
  - When sd_ack = 0 is sampled: pulse done[g] for one cycle and go to DONE.
- DONE:
  - One-cycle holdoff, then IDLE.
  - The requester must drop req_rd/req_wr by the cycle after done; the holdoff guarantees the same request is not re-granted.
- Request withdrawn after grant: ignored. The transfer runs to completion and done still pulses.
- sd_buff_wr while IDLE or ISSUE: no buff_wr bit asserts.
- Reset mid-transfer: strobes drop immediately, no done pulse, state returns to IDLE. hps_io is expected to finish its ack cycle on its own.
- Fairness: with all four slots requesting continuously, grants go 0,1,2,3,0,… with no slot starved.

Optional Feature:
- Macro: SD_BLOCK_ARBITER_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to ISSUE and increments each cycle in ISSUE.
  - On reaching TIMEOUT_CYCLES without an ack: drop the strobe, pulse err[g] and done[g] in the same cycle, go to DONE.
  - Ack arriving on the same cycle the count reaches the limit: ack wins, normal path.
- Undefined: no counter is built, err is tied to 0, and ISSUE waits indefinitely.

Test Plan:
- Single read: req_rd[2]=1, req_lba slot2=0x0000_1234 -> sd_rd=4'b0100 and sd_lba=0x1234 two cycles later. Hold sd_ack 8 cycles with sd_buff_wr pulses -> buff_wr=4'b0100 on each pulse. Ack falls -> done=4'b0100 for exactly 1 cycle.
- Round-robin: req_rd=4'b1111 held, each transfer acked 4 cycles -> cur_slot sequence 0,1,2,3,0 and sd_rd sequence 0001,0010,0100,1000,0001.
- Write path: req_wr[1]=1 with req_buff_din slot1=0xA5 and all other slots 0xFF -> sd_wr=4'b0010 and sd_buff_din=0xA5 during ack. In IDLE, sd_buff_din=0x00.
- rd/wr collision and withdrawal: req_rd[0]=req_wr[0]=1 -> sd_rd=4'b0001, sd_wr=0. Drop req_rd[0] during XFER -> transfer completes and done[0] pulses.
- Reset mid-XFER: assert reset while sd_ack=1 -> sd_rd=sd_wr=0, busy=0, no done pulse. After release, a req_rd[3] request is granted normally.
- Timeout (macro defined, TIMEOUT_CYCLES=100): req_rd[1]=1, sd_ack held 0 -> at cycle 100 of ISSUE, err=done=4'b0010 for 1 cycle and sd_rd returns to 0.
